// File: rtl/fifo_word_serializer.sv
// Drain stage for a 32-bit sync FIFO: pops one word at a time and streams it
// as four bytes on a valid/ready link, counting every word whose last byte is taken.
module fifo_word_serializer #(
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [31:0]      fifo_data,
  output logic             fifo_rd_en,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             byte_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] SEND = 2'd3;

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

  logic [1:0]  state;
  logic [1:0]  wait_cnt;
  logic [31:0] word;
  logic [1:0]  idx;
  logic [1:0]  lane;
  logic        accept;

  assign accept = byte_valid && byte_ready;

  // fifo_empty is looked at only in IDLE, so a word is never prefetched
  // while the previous one is still being sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fifo_rd_en <= 1'b0;
      byte_valid <= 1'b0;
      words_sent <= '0;
      word       <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            state      <= POP;
          end
        end
        POP: begin
          fifo_rd_en <= 1'b0;
          wait_cnt   <= WAIT_LOAD;
          state      <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            word       <= fifo_data;
            idx        <= '0;
            byte_valid <= 1'b1;
            state      <= SEND;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        SEND: begin
          if (accept) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              byte_valid <= 1'b0;
              words_sent <= words_sent + CNT_W'(1);
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MSB-first order is the LSB-first lane index reversed.
  always_comb begin
    lane = LSB_FIRST ? idx : ~idx;
    byte_out = '0;
    case (lane)
      2'd0: byte_out = word[7:0];
      2'd1: byte_out = word[15:8];
      2'd2: byte_out = word[23:16];
      2'd3: byte_out = word[31:24];
      default: byte_out = '0;
    endcase
  end

  assign byte_last = (state == SEND) && (idx == 2'd3);
  assign busy      = (state != IDLE);

endmodule
